// File: rtl/fifo_buffer_multi.sv
// Multi-channel FIFO: NUM_CHANNELS queues sharing one write port and one read port, with count/almost-full/flush.
// Optional sticky overflow/underflow flags when FIFO_ERR_FLAGS_EN is defined.
module fifo_buffer_multi #(
  parameter int DATA_WIDTH         = 36,
  parameter int BUFFER_ADDR_WIDTH  = 5,
  parameter int NUM_CHANNELS       = 4,
  parameter int ALMOST_FULL_THRESH = 28,
  localparam int CH_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [DATA_WIDTH-1:0]                        data_i,
  input  logic                                         wren_i,
  input  logic [CH_WIDTH-1:0]                          wr_ch_i,
  input  logic                                         rden_i,
  input  logic [CH_WIDTH-1:0]                          rd_ch_i,
  input  logic                                         flush_i,
  input  logic [CH_WIDTH-1:0]                          flush_ch_i,
  output logic [DATA_WIDTH-1:0]                        data_o,
  output logic                                         valid_o,
  output logic [CH_WIDTH-1:0]                          rd_ch_o,
  output logic [NUM_CHANNELS-1:0]                      empty_o,
  output logic [NUM_CHANNELS-1:0]                      full_o,
  output logic [NUM_CHANNELS-1:0]                      almost_full_o,
  output logic [NUM_CHANNELS*(BUFFER_ADDR_WIDTH+1)-1:0] count_o
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic [NUM_CHANNELS-1:0]                      overflow_o,
  output logic [NUM_CHANNELS-1:0]                      underflow_o
`endif
);

  localparam int BA    = BUFFER_ADDR_WIDTH;
  localparam int DEPTH = 1 << BA;
  localparam int CW    = BA + 1;

  typedef logic [BA:0] ptr_t;

  ptr_t wr_ptr_q [NUM_CHANNELS];
  ptr_t wr_ptr_d [NUM_CHANNELS];
  ptr_t rd_ptr_q [NUM_CHANNELS];
  ptr_t rd_ptr_d [NUM_CHANNELS];
  ptr_t count_w  [NUM_CHANNELS];

  logic [DATA_WIDTH-1:0] mem_q [NUM_CHANNELS][DEPTH];

  logic [NUM_CHANNELS-1:0] flush_hit, wr_hit, rd_hit, wr_acc, rd_acc;
  logic [NUM_CHANNELS-1:0] empty_w, full_w;

  logic [DATA_WIDTH-1:0] data_q, data_d, rd_word;
  logic                  valid_q, valid_d;
  logic [CH_WIDTH-1:0]   rd_ch_q, rd_ch_d;

  // Channel decode doubles as the range check: an out-of-range select matches no channel.
  always_comb begin
    flush_hit     = '0;
    wr_hit        = '0;
    rd_hit        = '0;
    wr_acc        = '0;
    rd_acc        = '0;
    empty_w       = '0;
    full_w        = '0;
    almost_full_o = '0;
    count_o       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      count_w[c]   = wr_ptr_q[c] - rd_ptr_q[c];
      empty_w[c]   = (count_w[c] == '0);
      full_w[c]    = (count_w[c] == CW'(DEPTH));
      almost_full_o[c] = (count_w[c] >= CW'(ALMOST_FULL_THRESH));
      count_o[c*CW +: CW] = count_w[c];
      flush_hit[c] = flush_i && (flush_ch_i == CH_WIDTH'(c));
      wr_hit[c]    = wren_i && (wr_ch_i == CH_WIDTH'(c)) && !flush_hit[c];
      rd_hit[c]    = rden_i && (rd_ch_i == CH_WIDTH'(c)) && !flush_hit[c];
      wr_acc[c]    = wr_hit[c] && !full_w[c];
      rd_acc[c]    = rd_hit[c] && !empty_w[c];
      wr_ptr_d[c]  = flush_hit[c] ? '0 : wr_ptr_q[c] + ptr_t'(wr_acc[c]);
      rd_ptr_d[c]  = flush_hit[c] ? '0 : rd_ptr_q[c] + ptr_t'(rd_acc[c]);
    end
  end

  assign empty_o = empty_w;
  assign full_o  = full_w;

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_acc[c]) rd_word = mem_q[c][rd_ptr_q[c][BA-1:0]];
    end
  end

  always_comb begin
    valid_d = |rd_acc;
    data_d  = data_q;
    rd_ch_d = rd_ch_q;
    if (valid_d) begin
      data_d  = rd_word;
      rd_ch_d = rd_ch_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      data_q  <= '0;
      valid_q <= 1'b0;
      rd_ch_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      data_q  <= data_d;
      valid_q <= valid_d;
      rd_ch_q <= rd_ch_d;
    end
  end

  // Storage is deliberately left unreset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_acc[c]) mem_q[c][wr_ptr_q[c][BA-1:0]] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign rd_ch_o = rd_ch_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic [NUM_CHANNELS-1:0] ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (flush_hit[c]) begin
        ovf_d[c] = 1'b0;
        udf_d[c] = 1'b0;
      end else begin
        ovf_d[c] = ovf_q[c] | (wr_hit[c] & full_w[c]);
        udf_d[c] = udf_q[c] | (rd_hit[c] & empty_w[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  // Dropped requests leave no trace.
`endif

endmodule
